// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN layer blocks.
// Lane geometry, collector FSM states and the output beat payload.
package cnn_pkg;

  localparam int unsigned NUM_NEURONS = 25;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned IDX_W       = 5;
  localparam int unsigned BUS_W       = NUM_NEURONS * DATA_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [IDX_W-1:0]  idx_t;

  localparam idx_t LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } collector_state_t;

  typedef struct packed {
    idx_t  index;
    data_t data;
    logic  last;
  } beat_t;

endpackage

// File: rtl/layer_result_collector_if.sv
// Neuron result bus plus streamed-beat and argmax outputs of the collector.
// slave = collector side, master = environment driving results/start/ready.
interface layer_result_collector_if;
  import cnn_pkg::*;

  logic [BUS_W-1:0] results;
  logic             start;
  logic             out_ready;
  logic             out_valid;
  data_t            out_data;
  idx_t             out_index;
  logic             out_last;
  logic             busy;
  logic             done;
  data_t            max_value;
  idx_t             max_index;

  modport slave (
    input  results, start, out_ready,
    output out_valid, out_data, out_index, out_last, busy, done, max_value, max_index
  );

  modport master (
    output results, start, out_ready,
    input  out_valid, out_data, out_index, out_last, busy, done, max_value, max_index
  );

endinterface

// File: rtl/result_argmax.sv
// Running max/index register; strict greater-than so the lowest index wins ties.
// next_*_c expose the value after the current update so the caller can latch it same-edge.
module result_argmax
  import cnn_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr_i,
  input  logic  en_i,
  input  logic  first_i,
  input  data_t val_i,
  input  idx_t  idx_i,
  output data_t next_val_c,
  output idx_t  next_idx_c
);

  data_t max_val_q, max_val_d;
  idx_t  max_idx_q, max_idx_d;

  always_comb begin
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    if (clr_i) begin
      max_val_d = '0;
      max_idx_d = '0;
    end else if (en_i && (first_i || (val_i > max_val_q))) begin
      max_val_d = val_i;
      max_idx_d = idx_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_val_q <= '0;
      max_idx_q <= '0;
    end else begin
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
    end
  end

  assign next_val_c = max_val_d;
  assign next_idx_c = max_idx_d;

endmodule

// File: rtl/layer_result_collector.sv
// Snapshots the neuron result bus on start and streams it one lane per beat,
// publishing the frame's argmax when the final beat is accepted.
module layer_result_collector
  import cnn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  layer_result_collector_if.slave  bus
);

  collector_state_t state_q, state_d;
  idx_t             idx_q, idx_d;
  idx_t             nxt_idx;
  data_t            buf_q [NUM_NEURONS];
  logic             snap_en;

  beat_t            beat_q, beat_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  data_t            max_value_q, max_value_d;
  idx_t             max_index_q, max_index_d;

  logic             am_clr, am_en;
  data_t            am_next_val;
  idx_t             am_next_idx;

  assign nxt_idx = idx_q + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = STREAM;
      STREAM:  if (bus.out_ready && (idx_q == LAST_IDX)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of every registered output plus buffer/argmax controls.
  always_comb begin
    snap_en     = 1'b0;
    idx_d       = idx_q;
    beat_d      = beat_q;
    valid_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    max_value_d = max_value_q;
    max_index_d = max_index_q;
    am_clr      = 1'b0;
    am_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          snap_en      = 1'b1;
          am_clr       = 1'b1;
          idx_d        = '0;
          valid_d      = 1'b1;
          busy_d       = 1'b1;
          beat_d.index = '0;
          beat_d.data  = bus.results[DATA_W-1:0];
          beat_d.last  = (LAST_IDX == '0);
        end
      end
      STREAM: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        if (bus.out_ready) begin
          am_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            valid_d     = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            max_value_d = am_next_val;
            max_index_d = am_next_idx;
          end else begin
            idx_d        = nxt_idx;
            beat_d.index = nxt_idx;
            beat_d.data  = buf_q[nxt_idx];
            beat_d.last  = (nxt_idx == LAST_IDX);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      beat_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      max_value_q <= '0;
      max_index_q <= '0;
    end else begin
      idx_q       <= idx_d;
      beat_q      <= beat_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      max_value_q <= max_value_d;
      max_index_q <= max_index_d;
    end
  end

  // Snapshot buffer: captured once per frame, immune to later bus changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) buf_q[i] <= '0;
    end else if (snap_en) begin
      for (int i = 0; i < NUM_NEURONS; i++) buf_q[i] <= bus.results[i*DATA_W +: DATA_W];
    end
  end

  result_argmax u_argmax (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (am_clr),
    .en_i       (am_en),
    .first_i    (idx_q == '0),
    .val_i      (buf_q[idx_q]),
    .idx_i      (idx_q),
    .next_val_c (am_next_val),
    .next_idx_c (am_next_idx)
  );

  assign bus.out_valid = valid_q;
  assign bus.out_data  = beat_q.data;
  assign bus.out_index = beat_q.index;
  assign bus.out_last  = beat_q.last;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.max_value = max_value_q;
  assign bus.max_index = max_index_q;

endmodule

// File: tb/tb_layer_result_collector.sv
// Self-checking bench: directed frames plus random frames, every cycle compared
// against a frame-level model (snapshot array, beat pointer, loop argmax).
module tb_layer_result_collector;
  import cnn_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layer_result_collector_if bus ();

  layer_result_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  bit m_zero   = 1'b1;
  int m_idx    = 0;
  int m_snap [NUM_NEURONS];
  int m_max_v  = 0;
  int m_max_i  = 0;

  function automatic void frame_argmax(input int s [NUM_NEURONS], output int v, output int ix);
    v  = s[0];
    ix = 0;
    for (int i = 1; i < NUM_NEURONS; i++)
      if (s[i] > v) begin
        v  = s[i];
        ix = i;
      end
  endfunction

  always @(negedge clk) begin
    bit nd;
    if (rst) begin
      check("rst_valid", 32'(bus.out_valid), 0);
      check("rst_data",  32'(bus.out_data),  0);
      check("rst_index", 32'(bus.out_index), 0);
      check("rst_last",  32'(bus.out_last),  0);
      check("rst_busy",  32'(bus.busy),      0);
      check("rst_done",  32'(bus.done),      0);
      check("rst_maxv",  32'(bus.max_value), 0);
      check("rst_maxi",  32'(bus.max_index), 0);
      m_active = 1'b0;
      m_done   = 1'b0;
      m_zero   = 1'b1;
      m_idx    = 0;
      m_max_v  = 0;
      m_max_i  = 0;
    end else begin
      check("out_valid", 32'(bus.out_valid), 32'(m_active));
      check("busy",      32'(bus.busy),      32'(m_active));
      check("done",      32'(bus.done),      32'(m_done));
      check("max_value", 32'(bus.max_value), 32'(m_max_v));
      check("max_index", 32'(bus.max_index), 32'(m_max_i));
      if (m_active) begin
        check("out_data",  32'(bus.out_data),  32'(m_snap[m_idx]));
        check("out_index", 32'(bus.out_index), 32'(m_idx));
        check("out_last",  32'(bus.out_last),  32'(m_idx == NUM_NEURONS - 1));
      end else if (m_zero) begin
        check("idle_data",  32'(bus.out_data),  0);
        check("idle_index", 32'(bus.out_index), 0);
        check("idle_last",  32'(bus.out_last),  0);
      end
      nd = 1'b0;
      if (m_active && bus.out_ready) begin
        if (m_idx == NUM_NEURONS - 1) begin
          m_active = 1'b0;
          nd       = 1'b1;
          frame_argmax(m_snap, m_max_v, m_max_i);
        end else begin
          m_idx++;
        end
      end else if (!m_active && !m_done && bus.start) begin
        for (int i = 0; i < NUM_NEURONS; i++) m_snap[i] = int'(bus.results[i*DATA_W +: DATA_W]);
        m_active = 1'b1;
        m_idx    = 0;
        m_zero   = 1'b0;
      end
      m_done = nd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic ready_for(input int mode, input int k);
    logic [3:0] pat;
    pat = 4'b1001;
    case (mode)
      0:       return 1'b1;
      1:       return pat[3 - (k % 4)];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic start_frame(input logic [BUS_W-1:0] img);
    bus.results = img;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  // k = cycles after the start edge until done is observed
  task automatic wait_done(input int mode, input int restart_at, output int k);
    k = 0;
    forever begin
      bus.out_ready = ready_for(mode, k);
      bus.start     = (k == restart_at);
      tick();
      k++;
      if (bus.done) break;
      if (k > 2000) begin
        n_checks++;
        n_errors++;
        $display("FAIL done_timeout: got no done after %0d cycles, expected done", k);
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  logic [BUS_W-1:0] img;
  logic [BUS_W-1:0] all_ff;
  int               k;

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    bus.results   = '0;
    all_ff        = '1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Ramp frame, ready held high
    for (int i = 0; i < NUM_NEURONS; i++) img[i*DATA_W +: DATA_W] = DATA_W'(i * 10);
    start_frame(img);
    check("t1_first_index", 32'(bus.out_index), 0);
    wait_done(0, -1, k);
    check("t1_latency",  32'(k), 25);
    check("t1_max_value", 32'(bus.max_value), 240);
    check("t1_max_index", 32'(bus.max_index), 24);
    tick();

    // Tie between lanes 3 and 17
    for (int i = 0; i < NUM_NEURONS; i++)
      img[i*DATA_W +: DATA_W] = (i == 3 || i == 17) ? 8'hF0 : 8'h55;
    start_frame(img);
    wait_done(0, -1, k);
    check("t2_max_value", 32'(bus.max_value), 32'h0F0);
    check("t2_max_index", 32'(bus.max_index), 3);
    tick();

    // Stall pattern 1,0,0,1
    for (int i = 0; i < NUM_NEURONS; i++) img[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    start_frame(img);
    wait_done(1, -1, k);
    check("t3_stall_latency", 32'(k), 49);
    tick();

    // Bus change after snapshot, second start mid-stream and start in DONE ignored
    for (int i = 0; i < NUM_NEURONS; i++) img[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
    start_frame(img);
    bus.results = all_ff;
    wait_done(0, 5, k);
    check("t4_latency",   32'(k), 25);
    check("t4_max_value", 32'(bus.max_value), 25);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t4_start_in_done_valid", 32'(bus.out_valid), 0);
    tick();
    check("t4_no_second_frame", 32'(bus.out_valid), 0);

    // Reset at beat 10, then fresh frame
    for (int i = 0; i < NUM_NEURONS; i++) img[i*DATA_W +: DATA_W] = DATA_W'(200 - i);
    start_frame(img);
    bus.out_ready = 1'b1;
    repeat (10) tick();
    check("t5_beat10_index", 32'(bus.out_index), 10);
    rst = 1'b1;
    tick();
    check("t5_rst_valid", 32'(bus.out_valid), 0);
    check("t5_rst_maxv",  32'(bus.max_value), 0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t5_no_done", 32'(bus.done), 0);
    end
    for (int i = 0; i < NUM_NEURONS; i++) img[i*DATA_W +: DATA_W] = DATA_W'(i * 7 + 3);
    start_frame(img);
    check("t5_restart_index", 32'(bus.out_index), 0);
    check("t5_restart_data",  32'(bus.out_data),  3);
    wait_done(0, -1, k);
    check("t5_max_value", 32'(bus.max_value), 171);
    check("t5_max_index", 32'(bus.max_index), 24);
    tick();

    // All zero frame; previous max held during the stream
    start_frame('0);
    check("t6_max_held_v", 32'(bus.max_value), 171);
    check("t6_max_held_i", 32'(bus.max_index), 24);
    wait_done(2, -1, k);
    check("t6_max_value", 32'(bus.max_value), 0);
    check("t6_max_index", 32'(bus.max_index), 0);
    tick();

    // Random frames with random backpressure, gaps and stray starts
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < NUM_NEURONS; i++)
        img[i*DATA_W +: DATA_W] = (f % 2 == 0) ? DATA_W'($urandom_range(0, 3)) : DATA_W'($urandom);
      start_frame(img);
      wait_done(2, int'($urandom_range(0, 40)), k);
      repeat ($urandom_range(1, 3)) tick();
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/layer_result_collector.md
# layer_result_collector

Reads the 25 parallel 8-bit neuron results of the first CNN layer, snapshots them on command, and streams them out one per beat over a valid/ready interface while tracking the argmax. Sits directly downstream of the `cnn` neuron array. It is the consumer/reader side of the neuron result bus and feeds the next layer or a host readout path.

## Interface
Parameters:
- `NUM_NEURONS`, 25, number of result lanes
- `DATA_W`, 8, width of one neuron result (unsigned)
- `IDX_W`, 5, index width, covers 0..NUM_NEURONS-1

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `results`  in  NUM_NEURONS*DATA_W  flat neuron result bus; lane i at bits [i*DATA_W +: DATA_W]
- `start`  in  1  request snapshot + stream; honoured only in IDLE
- `out_ready`  in  1  downstream accepts current beat
- `out_valid`  out  1  current beat valid
- `out_data`  out  DATA_W  result value of current beat
- `out_index`  out  IDX_W  neuron index of current beat
- `out_last`  out  1  high on beat with index NUM_NEURONS-1
- `busy`  out  1  high in STREAM
- `done`  out  1  one-cycle pulse after final beat accepted
- `max_value`  out  DATA_W  largest result of last completed frame
- `max_index`  out  IDX_W  index of that result

## Operation
- States: IDLE, STREAM, DONE.
- IDLE: `start`=1 → copy all lanes of `results` into internal buffer, index counter ← 0, running max ← lane 0 candidate cleared, go STREAM.
- STREAM: `out_valid`=1, `out_data`=buffer[idx], `out_index`=idx, `out_last`=(idx==NUM_NEURONS-1). On `out_valid && out_ready`: compare buffer[idx] to running max; update if idx==0 or strictly greater (unsigned); idx+1. Handshake on last beat → DONE.
- DONE: `done`=1 for exactly one cycle; `max_value`/`max_index` registered from running max; → IDLE.
- Ties: lowest index wins (strict greater-than compare).
- `start` while STREAM or DONE: ignored, no queueing.
- `start` in IDLE on the same edge DONE returns to IDLE: only possible from the following cycle; DONE never accepts start.
- Changes on `results` after snapshot do not affect the stream.
- `out_data`/`out_index` stable while `out_valid && !out_ready` (no drop, no skip).
- `max_value`/`max_index` hold prior frame's values through a new STREAM until its DONE.
- Reset (any time, including mid-stream): state IDLE, idx 0, buffer cleared, all outputs 0; partial frame discarded, no `done`.

## Timing
- Reset values: `out_valid`, `out_data`, `out_index`, `out_last`, `busy`, `done`, `max_value`, `max_index` all 0.
- `start` sampled high at edge t → `out_valid`=1 and `busy`=1 from cycle t+1, beat 0 presented.
- With `out_ready` held high: one beat per cycle, beats 0..24 in cycles t+1..t+25; `done` in t+26; `max_*` valid from t+26; earliest next start accepted at edge ending cycle t+27 (IDLE).
- Each stalled cycle (`out_ready`=0) adds one cycle of latency.
- All outputs registered; no combinational path from `out_ready` or `start` to any output.

## Structure
- Shared package `cnn_pkg`: `NUM_NEURONS`, `DATA_W`, `IDX_W` constants and state enum type `collector_state_t` {IDLE, STREAM, DONE}; reused by future layer blocks.
- One natural sub-module: `result_argmax` — running max/index register with clear, update-enable, value/index inputs; strict-greater compare.
- Snapshot buffer as register array indexed by counter; no memory macro.

## Test plan
- Reset then `results` lane i = i*10 (0..240), pulse `start`, `out_ready`=1 → beats index 0..24 data 0..240 on consecutive cycles, `out_last` only on index 24, `done` next cycle, `max_value`=240, `max_index`=24.
- All lanes 0x55 except lanes 3 and 17 = 0xF0 → `max_value`=0xF0, `max_index`=3 (tie → lowest).
- `out_ready` toggled 1,0,0,1 pattern during stream → no beat dropped/repeated; data held during stalls; `done` delayed by stall count.
- Change `results` to all 0xFF immediately after start accepted → streamed data equals snapshot; second `start` mid-stream ignored (single `done`).
- Assert `rst` at beat 10 → all outputs 0 next cycle, no `done`; new `start` restarts at index 0 with fresh snapshot.
- All lanes 0 → 25 beats of 0, `max_value`=0, `max_index`=0; previous frame's `max_*` held until this `done`.
